// File: rtl/imm_gen_pipe_pkg.sv
// ------------------------------------------------------------------
// imm_pkg: format codes, opcodes and entry type for imm_gen_pipe.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  localparam int IMM_W_MAX = 64;
  localparam int TAG_W_MAX = 16;

  // Widest-configuration entry layout (XLEN=64, tags up to 16 bits).
  typedef struct packed {
    logic [IMM_W_MAX-1:0] imm;
    fmt_e                 fmt;
    logic                 illegal;
    logic [TAG_W_MAX-1:0] tag;
  } imm_entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
// ------------------------------------------------------------------
// imm_decode: combinational opcode/funct3 immediate decoder.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] shamt5;
  logic [XLEN-1:0] shamt6;

  assign opc      = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign shamt5 = {{(XLEN-5){1'b0}}, instr[24:20]};
  assign shamt6 = {{(XLEN-6){1'b0}}, instr[25:20]};

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opc)
      OPC_LOAD, OPC_JALR: begin
        fmt = FMT_I;
        imm = imm_i;
      end
      OPC_OPIMM: begin
        if (!is_shift) begin
          fmt = FMT_I;
          imm = imm_i;
        end else begin
          fmt = FMT_SHAMT;
          if (IS64) begin
            imm = shamt6;
          end else if (instr[25]) begin
            illegal = 1'b1;
          end else begin
            imm = shamt5;
          end
        end
      end
      OPC_OPIMM32: begin
        // Word-sized ops only exist on RV64 and always shift by 5 bits.
        if (!IS64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt = FMT_SHAMT;
          imm = shamt5;
        end else begin
          fmt = FMT_I;
          imm = imm_i;
        end
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = imm_s;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = imm_u;
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = imm_j;
      end
      OPC_OP, OPC_SYSTEM: begin
        fmt = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ------------------------------------------------------------------
// imm_gen_pipe: registered immediate generator with 2-entry skid buffer.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t          main_q;
  entry_t          skid_q;
  entry_t          dec_e;
  logic            main_valid;
  logic            skid_valid;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic            accept_in;
  logic            pop;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr  (in_instr),
    .imm    (dec_imm),
    .fmt    (dec_fmt),
    .illegal(dec_illegal)
  );

  assign dec_e     = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};
  assign in_ready  = !skid_valid;
  assign accept_in = in_valid && in_ready;
  assign pop       = main_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      // A full skid implies in_ready=0, so no new input competes here.
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept_in) begin
        main_q <= dec_e;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept_in) begin
      if (main_valid) begin
        skid_q     <= dec_e;
        skid_valid <= 1'b1;
      end else begin
        main_q     <= dec_e;
        main_valid <= 1'b1;
      end
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule

`default_nettype wire
